mux_operand_sequencer: RTL and testbench

- Upstream feeder for the 4-bit 2-input mux stage. Accepts 4-bit words over a valid/ready handshake and captures them as operand A and operand B.
- Then drives the mux select line through a fixed number of alternating phases, so the downstream mux emits A,B,A,B,...
- Drives the mux Input_1 (op_a), Input_2 (op_b) and S (sel) pins directly.
- Encoding: sel=0 routes op_a; sel=1 routes op_b.

---
 rtl/mux_operand_sequencer.sv | 143 ++++++++++++++
 tb/tb_mux_operand_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_operand_sequencer.sv
// Purpose: captures operand A then B over valid/ready and plays them into a 2:1 mux as A,B,A,B... for REPEAT phases.
// Latency: first phase valid the cycle after the B transfer; done pulses the cycle after the last phase.
// Backpressure: in_ready is high only in IDLE/WAIT_B; abort cancels from any state. Optional pause via `MUX_SEQ_PAUSE_EN.
module mux_operand_sequencer #(
    parameter int WIDTH  = 4,
    parameter int REPEAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
`ifdef MUX_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             sel,
    output logic             play_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_B = 2'd1;
    localparam logic [1:0] PLAY   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Index of the final phase; REPEAT is limited to 1..15 so it fits the 4-bit counter.
    localparam logic [3:0] LAST_PHASE = 4'(REPEAT - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             sel_q, sel_d;
    logic [3:0]       phase_cnt_q, phase_cnt_d;
    logic             play_valid_q, play_valid_d;
    logic             done_q, done_d;
    logic             xfer;
    logic             pause_act;

`ifdef MUX_SEQ_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    // Handshake status is a pure decode of the state register.
    assign in_ready   = (state_q == IDLE) || (state_q == WAIT_B);
    assign busy       = (state_q != IDLE);
    assign xfer       = in_valid && in_ready;

    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign sel        = sel_q;
    assign play_valid = play_valid_q;
    assign done       = done_q;

    // Next-state logic: operand capture, phase sequencing, and abort override.
    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        sel_d        = sel_q;
        phase_cnt_d  = phase_cnt_q;
        play_valid_d = play_valid_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    op_a_d  = in_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (xfer) begin
                    op_b_d       = in_data;
                    sel_d        = 1'b0;
                    phase_cnt_d  = 4'd0;
                    play_valid_d = 1'b1;
                    state_d      = PLAY;
                end
            end
            PLAY: begin
                if (pause_act) begin
                    // Freeze the phase; the held phase is not re-presented as valid.
                    play_valid_d = 1'b0;
                end else if (phase_cnt_q == LAST_PHASE) begin
                    phase_cnt_d  = phase_cnt_q + 4'd1;
                    play_valid_d = 1'b0;
                    sel_d        = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end else begin
                    phase_cnt_d  = phase_cnt_q + 4'd1;
                    sel_d        = ~sel_q;
                    play_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything, including a same-cycle transfer; operands are kept.
        if (abort) begin
            state_d      = IDLE;
            sel_d        = 1'b0;
            play_valid_d = 1'b0;
            done_d       = 1'b0;
            phase_cnt_d  = 4'd0;
            op_a_d       = op_a_q;
            op_b_d       = op_b_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sel_q        <= 1'b0;
            phase_cnt_q  <= 4'd0;
            play_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sel_q        <= sel_d;
            phase_cnt_q  <= phase_cnt_d;
            play_valid_q <= play_valid_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_mux_operand_sequencer.sv
// Directed bench for mux_operand_sequencer: a REPEAT=4 instance and a REPEAT=1 instance.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Pause scenario is exercised only when MUX_SEQ_PAUSE_EN is defined.
module tb_mux_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] op_a, op_b;
    logic       in_ready, sel, play_valid, busy, done;
`ifdef MUX_SEQ_PAUSE_EN
    logic       pause = 1'b0;
    logic       pause1 = 1'b0;
`endif

    logic [3:0] d1_data = 4'h0;
    logic       d1_valid = 1'b0;
    logic       d1_abort = 1'b0;
    logic [3:0] d1_op_a, d1_op_b;
    logic       d1_ready, d1_sel, d1_pv, d1_busy, d1_done;

    int errors = 0;
    int checks = 0;

    // Downstream mux as seen on the board: S=0 -> Input_1, S=1 -> Input_2.
    logic [3:0] mux_out, d1_mux_out;
    assign mux_out    = sel ? op_b : op_a;
    assign d1_mux_out = d1_sel ? d1_op_b : d1_op_a;

    always #5 clk = ~clk;

    mux_operand_sequencer #(.WIDTH(4), .REPEAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort),
`ifdef MUX_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .op_a(op_a), .op_b(op_b), .sel(sel), .play_valid(play_valid),
        .busy(busy), .done(done)
    );

    mux_operand_sequencer #(.WIDTH(4), .REPEAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1_data), .in_valid(d1_valid),
        .in_ready(d1_ready), .abort(d1_abort),
`ifdef MUX_SEQ_PAUSE_EN
        .pause(pause1),
`endif
        .op_a(d1_op_a), .op_b(d1_op_b), .sel(d1_sel), .play_valid(d1_pv),
        .busy(d1_busy), .done(d1_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Everything cleared while rst_n is low, before any clock edge.
    task automatic test_reset();
        logic [14:0] got;
        rst_n = 1'b0;
        #2;
        got = {op_a, op_b, sel, play_valid, done, in_ready, busy, d1_ready, d1_done};
        checks++;
        if (got !== 15'b0000_0000_000_10_10) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", got, 15'b0000_0000_000_10_10);
        end
        #5 rst_n = 1'b1;
        tick();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected 10", {in_ready, busy});
        end
    endtask

    // 0x3 then 0xC: four phases 3,C,3,C then a one-cycle done.
    task automatic test_basic();
        logic [6:0] got, exp;
        in_data = 4'h3; in_valid = 1'b1;
        tick();
        checks++;
        if ({op_a, in_ready, busy} !== {4'h3, 2'b11}) begin
            errors++;
            $display("FAIL basic_wait_b: got %b expected %b", {op_a, in_ready, busy}, {4'h3, 2'b11});
        end
        in_data = 4'hC;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got = {sel, play_valid, mux_out, in_ready};
            exp = {(i % 2 == 1), 1'b1, (i % 2 == 1) ? 4'hC : 4'h3, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_phase%0d: got %b expected %b", i, got, exp);
            end
            tick();
        end
        checks++;
        if ({done, play_valid, sel, in_ready, busy} !== 5'b10001) begin
            errors++;
            $display("FAIL basic_done: got %b expected 10001", {done, play_valid, sel, in_ready, busy});
        end
        tick();
        checks++;
        if ({done, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL basic_back_idle: got %b expected 010", {done, in_ready, busy});
        end
    endtask

    // in_valid held with 0x7 during PLAY/DONE; captured only once IDLE is reached.
    task automatic test_backpressure();
        in_data = 4'h3; in_valid = 1'b1;
        tick();
        in_data = 4'hC;
        tick();
        in_data = 4'h7;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({in_ready, op_a, op_b} !== {1'b0, 4'h3, 4'hC}) begin
                errors++;
                $display("FAIL bp_hold%0d: got %b expected %b", i, {in_ready, op_a, op_b}, {1'b0, 4'h3, 4'hC});
            end
            tick();
        end
        checks++;
        if ({in_ready, busy, op_a} !== {2'b10, 4'h3}) begin
            errors++;
            $display("FAIL bp_idle_before_capture: got %b expected %b", {in_ready, busy, op_a}, {2'b10, 4'h3});
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({op_a, op_b, busy} !== {4'h7, 4'hC, 1'b1}) begin
            errors++;
            $display("FAIL bp_capture: got %h/%h busy=%b expected 7/c busy=1", op_a, op_b, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    // Abort beats a same-cycle B transfer; abort mid-PLAY clears sel/play_valid.
    task automatic test_abort();
        in_data = 4'h5; in_valid = 1'b1;
        tick();
        in_data = 4'h9; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        checks++;
        if ({busy, done, op_a, op_b} !== {2'b00, 4'h5, 4'hC}) begin
            errors++;
            $display("FAIL abort_wait_b: got %b expected %b", {busy, done, op_a, op_b}, {2'b00, 4'h5, 4'hC});
        end
        tick();
        checks++;
        if ({done, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL abort_no_done: got %b expected 01", {done, in_ready});
        end
        in_data = 4'h1; in_valid = 1'b1;
        tick();
        in_data = 4'h2;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({sel, play_valid} !== 2'b11) begin
            errors++;
            $display("FAIL abort_second_phase: got %b expected 11", {sel, play_valid});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({sel, play_valid, busy, done, op_a, op_b} !== {4'b0000, 4'h1, 4'h2}) begin
            errors++;
            $display("FAIL abort_play: got %b expected %b", {sel, play_valid, busy, done, op_a, op_b}, {4'b0000, 4'h1, 4'h2});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_play_no_done: got %b expected 0", done);
        end
    endtask

    // REPEAT=1: single phase with sel=0 showing A, done on the following cycle.
    task automatic test_repeat1();
        d1_data = 4'hA; d1_valid = 1'b1;
        tick();
        d1_data = 4'h5;
        tick();
        d1_valid = 1'b0;
        checks++;
        if ({d1_sel, d1_pv, d1_mux_out, d1_done} !== {2'b01, 4'hA, 1'b0}) begin
            errors++;
            $display("FAIL r1_phase: got %b expected %b", {d1_sel, d1_pv, d1_mux_out, d1_done}, {2'b01, 4'hA, 1'b0});
        end
        tick();
        checks++;
        if ({d1_done, d1_pv, d1_sel, d1_busy} !== 4'b1001) begin
            errors++;
            $display("FAIL r1_done: got %b expected 1001", {d1_done, d1_pv, d1_sel, d1_busy});
        end
        tick();
        checks++;
        if ({d1_done, d1_ready, d1_busy} !== 3'b010) begin
            errors++;
            $display("FAIL r1_idle: got %b expected 010", {d1_done, d1_ready, d1_busy});
        end
    endtask

    // Reset dropped mid-PLAY, mid-cycle: outputs clear before the next edge.
    task automatic test_async_reset();
        logic [13:0] got;
        in_data = 4'h6; in_valid = 1'b1;
        tick();
        in_data = 4'h9;
        tick();
        in_valid = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        got = {op_a, op_b, sel, play_valid, done, in_ready, busy, phase_probe()};
        checks++;
        if (got !== 14'b0000_0000_000_10_0) begin
            errors++;
            $display("FAIL async_reset_mid_play: got %b expected %b", got, 14'b0000_0000_000_10_0);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if ({play_valid, busy, in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL async_reset_release: got %b expected 001", {play_valid, busy, in_ready});
        end
    endtask

    function automatic logic phase_probe();
        return d1_done;
    endfunction

`ifdef MUX_SEQ_PAUSE_EN
    // Pause for two cycles after phase 1: sel held at 1 with play_valid low, then phases 2,3, done two cycles late.
    task automatic test_pause();
        logic [1:0] exp [0:6];
        exp[0] = 2'b01; exp[1] = 2'b11; exp[2] = 2'b10; exp[3] = 2'b10;
        exp[4] = 2'b01; exp[5] = 2'b11; exp[6] = 2'b00;
        in_data = 4'h3; in_valid = 1'b1;
        tick();
        in_data = 4'hC;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            pause = (i == 1 || i == 2);
            checks++;
            if ({sel, play_valid} !== exp[i]) begin
                errors++;
                $display("FAIL pause_step%0d: got %b expected %b", i, {sel, play_valid}, exp[i]);
            end
            checks++;
            if (done !== (i == 6)) begin
                errors++;
                $display("FAIL pause_done%0d: got %b expected %b", i, done, (i == 6));
            end
            tick();
        end
        pause = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_repeat1();
        test_async_reset();
`ifdef MUX_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
